strassen_2x2_engine: RTL and testbench

STRASSEN_2X2_ENGINE -- requirements
Module: strassen_2x2_engine

---
 rtl/strassen_pkg.sv | 39 +++
 rtl/strassen_mul.sv | 20 ++
 rtl/strassen_2x2_engine.sv | 197 +++++++++++++++++++
 tb/tb_strassen_2x2_engine.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/strassen_pkg.sv
// Shared types and constants for the 2x2 Strassen/naive matrix multiply engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package strassen_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_MULT    = 3'd2,
    S_COMBINE = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  localparam logic MODE_STRASSEN = 1'b0;
  localparam logic MODE_NAIVE    = 1'b1;

  localparam logic [3:0] NPROD_STRASSEN = 4'd7;
  localparam logic [3:0] NPROD_NAIVE    = 4'd8;

  // Strassen product slots, issued in this order
  localparam logic [2:0] M1 = 3'd0;
  localparam logic [2:0] M2 = 3'd1;
  localparam logic [2:0] M3 = 3'd2;
  localparam logic [2:0] M4 = 3'd3;
  localparam logic [2:0] M5 = 3'd4;
  localparam logic [2:0] M6 = 3'd5;
  localparam logic [2:0] M7 = 3'd6;

  // Naive product slots a_ik*b_kj, issued in this order
  localparam logic [2:0] N11_11 = 3'd0;
  localparam logic [2:0] N12_21 = 3'd1;
  localparam logic [2:0] N11_12 = 3'd2;
  localparam logic [2:0] N12_22 = 3'd3;
  localparam logic [2:0] N21_11 = 3'd4;
  localparam logic [2:0] N22_21 = 3'd5;
  localparam logic [2:0] N21_12 = 3'd6;
  localparam logic [2:0] N22_22 = 3'd7;

endpackage

// File: rtl/strassen_mul.sv
// Signed OWxOW multiplier with a single output register.
// Latency: 1 cycle, result valid the cycle after operands are presented.
// Backpressure: none; free-running every cycle.
module strassen_mul #(
  parameter int OW = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [OW-1:0]   a,
  input  logic signed [OW-1:0]   b,
  output logic signed [2*OW-1:0] p
);

  // Register the full-width signed product
  always_ff @(posedge clk) begin
    if (rst) p <= '0;
    else     p <= a * b;
  end

endmodule

// File: rtl/strassen_2x2_engine.sv
// 2x2 signed matrix multiply, Strassen (7 products) or naive (8 products), one multiplier.
// Latency: 10 (Strassen) / 11 (naive) cycles from 4th accepted beat to first result beat.
// Backpressure: result beats held stable while c_valid && !c_ready; inputs only taken in LOAD.
module strassen_2x2_engine
  import strassen_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  localparam int ACC_WIDTH  = 2*DATA_WIDTH+4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         mode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] a_data,
  input  logic signed [DATA_WIDTH-1:0] b_data,
  output logic                         c_valid,
  input  logic                         c_ready,
  output logic signed [ACC_WIDTH-1:0]  c_data,
  output logic                         c_last,
  output logic                         busy,
  output logic                         done
);

  localparam int OW = DATA_WIDTH + 1;   // pre-add width
  localparam int PW = 2*OW;             // product width

  state_t state_q, state_d;
  logic                         mode_q;
  logic [1:0]                   beat_q;
  logic [3:0]                   mul_cnt_q;
  logic                         done_q;
  logic signed [DATA_WIDTH-1:0] a_q [4];
  logic signed [DATA_WIDTH-1:0] b_q [4];
  logic signed [PW-1:0]         prod_q [8];
  logic signed [ACC_WIDTH-1:0]  c_q [4];

  logic                 in_hs, out_hs;
  logic [3:0]           nprod;
  logic signed [OW-1:0] a11, a12, a21, a22, b11, b12, b21, b22;
  logic signed [OW-1:0] op_a, op_b;
  logic signed [PW-1:0] mul_p;

  function automatic logic signed [ACC_WIDTH-1:0] sx(input logic signed [PW-1:0] p);
    return {{(ACC_WIDTH-PW){p[PW-1]}}, p};
  endfunction

  assign in_hs  = (state_q == S_LOAD) && in_valid;
  assign out_hs = (state_q == S_OUT) && c_ready;
  assign nprod  = (mode_q == MODE_NAIVE) ? NPROD_NAIVE : NPROD_STRASSEN;
  assign done   = done_q;

  // Operands stored row-major; sign-extend once so every pre-add has headroom
  assign a11 = {a_q[0][DATA_WIDTH-1], a_q[0]};
  assign a12 = {a_q[1][DATA_WIDTH-1], a_q[1]};
  assign a21 = {a_q[2][DATA_WIDTH-1], a_q[2]};
  assign a22 = {a_q[3][DATA_WIDTH-1], a_q[3]};
  assign b11 = {b_q[0][DATA_WIDTH-1], b_q[0]};
  assign b12 = {b_q[1][DATA_WIDTH-1], b_q[1]};
  assign b21 = {b_q[2][DATA_WIDTH-1], b_q[2]};
  assign b22 = {b_q[3][DATA_WIDTH-1], b_q[3]};

  // Select the pre-added operand pair for the product issued this cycle
  always_comb begin
    op_a = '0;
    op_b = '0;
    if (state_q == S_MULT && mul_cnt_q < nprod) begin
      if (mode_q == MODE_STRASSEN) begin
        case (mul_cnt_q[2:0])
          M1: begin op_a = a11 + a22; op_b = b11 + b22; end
          M2: begin op_a = a21 + a22; op_b = b11;       end
          M3: begin op_a = a11;       op_b = b12 - b22; end
          M4: begin op_a = a22;       op_b = b21 - b11; end
          M5: begin op_a = a11 + a12; op_b = b22;       end
          M6: begin op_a = a21 - a11; op_b = b11 + b12; end
          M7: begin op_a = a12 - a22; op_b = b21 + b22; end
          default: begin op_a = '0; op_b = '0; end
        endcase
      end else begin
        case (mul_cnt_q[2:0])
          N11_11: begin op_a = a11; op_b = b11; end
          N12_21: begin op_a = a12; op_b = b21; end
          N11_12: begin op_a = a11; op_b = b12; end
          N12_22: begin op_a = a12; op_b = b22; end
          N21_11: begin op_a = a21; op_b = b11; end
          N22_21: begin op_a = a22; op_b = b21; end
          N21_12: begin op_a = a21; op_b = b12; end
          N22_22: begin op_a = a22; op_b = b22; end
          default: begin op_a = '0; op_b = '0; end
        endcase
      end
    end
  end

  strassen_mul #(.OW(OW)) u_mul (
    .clk (clk),
    .rst (rst),
    .a   (op_a),
    .b   (op_b),
    .p   (mul_p)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    c_valid  = 1'b0;
    c_last   = 1'b0;
    c_data   = '0;
    busy     = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_hs && beat_q == 2'd3) state_d = S_MULT;
      end
      S_MULT: begin
        // last cycle drains the multiplier register into the product bank
        if (mul_cnt_q == nprod) state_d = S_COMBINE;
      end
      S_COMBINE: begin
        state_d = S_OUT;
      end
      S_OUT: begin
        c_valid = 1'b1;
        c_data  = c_q[beat_q];
        c_last  = (beat_q == 2'd3);
        if (out_hs && beat_q == 2'd3) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: operand capture, product bank, combine, output beat index
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_STRASSEN;
      beat_q    <= '0;
      mul_cnt_q <= '0;
      done_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        c_q[i] <= '0;
      end
      for (int i = 0; i < 8; i++) prod_q[i] <= '0;
    end else begin
      done_q <= out_hs && (beat_q == 2'd3);
      case (state_q)
        S_IDLE: begin
          beat_q    <= '0;
          mul_cnt_q <= '0;
          if (start) mode_q <= mode;
        end
        S_LOAD: begin
          if (in_hs) begin
            a_q[beat_q] <= a_data;
            b_q[beat_q] <= b_data;
            beat_q      <= beat_q + 2'd1;
          end
        end
        S_MULT: begin
          mul_cnt_q <= mul_cnt_q + 4'd1;
          // product issued last cycle is now on the multiplier output
          if (mul_cnt_q != 4'd0) prod_q[3'(mul_cnt_q - 4'd1)] <= mul_p;
        end
        S_COMBINE: begin
          if (mode_q == MODE_STRASSEN) begin
            c_q[0] <= sx(prod_q[M1]) + sx(prod_q[M4]) - sx(prod_q[M5]) + sx(prod_q[M7]);
            c_q[1] <= sx(prod_q[M3]) + sx(prod_q[M5]);
            c_q[2] <= sx(prod_q[M2]) + sx(prod_q[M4]);
            c_q[3] <= sx(prod_q[M1]) - sx(prod_q[M2]) + sx(prod_q[M3]) + sx(prod_q[M6]);
          end else begin
            c_q[0] <= sx(prod_q[N11_11]) + sx(prod_q[N12_21]);
            c_q[1] <= sx(prod_q[N11_12]) + sx(prod_q[N12_22]);
            c_q[2] <= sx(prod_q[N21_11]) + sx(prod_q[N22_21]);
            c_q[3] <= sx(prod_q[N21_12]) + sx(prod_q[N22_22]);
          end
        end
        S_OUT: begin
          if (out_hs) beat_q <= beat_q + 2'd1;
        end
        default: beat_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_strassen_2x2_engine.sv
// Directed bench for strassen_2x2_engine: hand-computed 2x2 products in both modes.
// Inputs driven and outputs sampled on the falling edge.
// Covers latency, result backpressure, back-to-back jobs and mid-job reset.
module tb_strassen_2x2_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, start, mode, in_valid, in_ready;
  logic               c_valid, c_ready, c_last, busy, done;
  logic signed [15:0] a_data, b_data;
  logic signed [35:0] c_data;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int jobs     = 0;

  logic signed [15:0] va [4];
  logic signed [15:0] vb [4];
  longint             vc [4];

  strassen_2x2_engine #(.DATA_WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .b_data   (b_data),
    .c_valid  (c_valid),
    .c_ready  (c_ready),
    .c_data   (c_data),
    .c_last   (c_last),
    .busy     (busy),
    .done     (done)
  );

  // done is registered, so its value before the edge is the pulse of the cycle just ended
  always @(posedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_vec(input int a0, input int a1, input int a2, input int a3,
                         input int b0, input int b1, input int b2, input int b3,
                         input longint c0, input longint c1, input longint c2, input longint c3);
    va[0] = 16'(a0); va[1] = 16'(a1); va[2] = 16'(a2); va[3] = 16'(a3);
    vb[0] = 16'(b0); vb[1] = 16'(b1); vb[2] = 16'(b2); vb[3] = 16'(b3);
    vc[0] = c0; vc[1] = c1; vc[2] = c2; vc[3] = c3;
  endtask

  // Called on a falling edge; start is raised immediately so a call made in the
  // done cycle exercises back-to-back acceptance.
  task automatic start_and_load(input logic m);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    mode  = ~m;
    chk("busy_after_start", longint'(busy), 64'sd1);
    for (int i = 0; i < 4; i++) begin
      chk("in_ready_load", longint'(in_ready), 64'sd1);
      in_valid = 1'b1;
      a_data   = va[i];
      b_data   = vb[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    a_data   = '0;
    b_data   = '0;
  endtask

  task automatic collect(input longint exp_lat, input int stall, input bit junk);
    int lat;
    lat = 1;
    while (!c_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", longint'(lat), exp_lat);
    for (int j = 0; j < 4; j++) begin
      for (int s = 0; s < stall; s++) begin
        start    = junk;
        in_valid = junk;
        chk("stall_valid", longint'(c_valid), 64'sd1);
        chk("stall_data", longint'(c_data), vc[j]);
        @(negedge clk);
        if (junk) chk("in_ready_in_out", longint'(in_ready), 64'sd0);
      end
      start    = 1'b0;
      in_valid = 1'b0;
      chk("c_valid", longint'(c_valid), 64'sd1);
      chk("c_data", longint'(c_data), vc[j]);
      chk("c_last", longint'(c_last), (j == 3) ? 64'sd1 : 64'sd0);
      c_ready = 1'b1;
      @(negedge clk);
      c_ready = 1'b0;
    end
    chk("done_pulse", longint'(done), 64'sd1);
    chk("c_valid_after", longint'(c_valid), 64'sd0);
    chk("busy_after", longint'(busy), 64'sd0);
    jobs++;
  endtask

  initial begin
    int stale;
    rst = 1'b1; start = 1'b0; mode = 1'b0; in_valid = 1'b0;
    a_data = '0; b_data = '0; c_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 64'sd0);
    chk("rst_c_valid", longint'(c_valid), 64'sd0);
    chk("rst_c_last", longint'(c_last), 64'sd0);
    chk("rst_c_data", longint'(c_data), 64'sd0);
    chk("rst_busy", longint'(busy), 64'sd0);
    chk("rst_done", longint'(done), 64'sd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic product, Strassen then naive back-to-back
    set_vec(1, 2, 3, 4, 5, 6, 7, 8, 64'sd19, 64'sd22, 64'sd43, 64'sd50);
    start_and_load(1'b0);
    collect(64'sd10, 0, 1'b0);
    start_and_load(1'b1);
    collect(64'sd11, 0, 1'b0);

    // Most negative operands: 2 * 2^30 in every element, no wrap
    set_vec(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768,
            64'sd2147483648, 64'sd2147483648, 64'sd2147483648, 64'sd2147483648);
    start_and_load(1'b0);
    collect(64'sd10, 0, 1'b0);
    start_and_load(1'b1);
    collect(64'sd11, 0, 1'b0);

    // Mixed signs with 3-cycle stalls per beat and junk start/in_valid during OUT
    set_vec(-3, 5, 7, -2, 4, -6, -1, 8, -64'sd17, 64'sd58, 64'sd30, -64'sd58);
    repeat (2) @(negedge clk);
    start_and_load(1'b0);
    collect(64'sd10, 3, 1'b1);

    // Extreme opposite signs: 2 * 32767 * -32768
    set_vec(32767, 32767, 32767, 32767, -32768, -32768, -32768, -32768,
            -64'sd2147418112, -64'sd2147418112, -64'sd2147418112, -64'sd2147418112);
    start_and_load(1'b0);
    collect(64'sd10, 0, 1'b0);
    set_vec(32767, 32767, 32767, 32767, -32768, -32768, -32768, -32768,
            -64'sd2147418112, -64'sd2147418112, -64'sd2147418112, -64'sd2147418112);
    start_and_load(1'b1);
    collect(64'sd11, 1, 1'b0);

    // Reset in the middle of MULT discards the job
    set_vec(11, 12, 13, 14, 15, 16, 17, 18, 64'sd0, 64'sd0, 64'sd0, 64'sd0);
    repeat (2) @(negedge clk);
    start_and_load(1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", longint'(busy), 64'sd0);
    chk("midrst_in_ready", longint'(in_ready), 64'sd0);
    chk("midrst_c_data", longint'(c_data), 64'sd0);
    stale = 0;
    for (int i = 0; i < 15; i++) begin
      if (c_valid || busy || done) stale++;
      @(negedge clk);
    end
    chk("midrst_no_stale", longint'(stale), 64'sd0);

    set_vec(1, 0, 0, 1, 9, -1, 0, 7, 64'sd9, -64'sd1, 64'sd0, 64'sd7);
    start_and_load(1'b0);
    collect(64'sd10, 0, 1'b0);

    repeat (3) @(negedge clk);
    chk("done_count", longint'(done_cnt), longint'(jobs));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
